// File: rtl/lut_config_loader_if.sv
// Bus between the LUT config loader and its environment: serial bitstream in,
// LUT write port and status out.
interface lut_config_loader_if #(
  parameter int ADDR_W   = 3,
  parameter int LUT_BITS = 32
);
  // serial_valid qualifies serial_in for exactly one rising edge; there is no
  // ready because the loader accepts a valid bit on every cycle it is busy.
  logic                start;
  logic                serial_in;
  logic                serial_valid;
  logic                lut_wr_en;
  logic [ADDR_W-1:0]   lut_wr_addr;
  logic [LUT_BITS-1:0] lut_wr_data;
  logic                busy;
  logic                config_done;
  logic [2:0]          state_dbg;

  modport slave (
    input  start, serial_in, serial_valid,
    output lut_wr_en, lut_wr_addr, lut_wr_data, busy, config_done, state_dbg
  );

  modport master (
    output start, serial_in, serial_valid,
    input  lut_wr_en, lut_wr_addr, lut_wr_data, busy, config_done, state_dbg
  );
endinterface

// File: rtl/lut_config_loader.sv
// Deserialises a config bitstream, locks onto a sync word, skips the header and
// writes NUM_LUTS truth-table words into LUT slots 0..NUM_LUTS-1.
module lut_config_loader #(
  parameter int                  NUM_LUTS     = 8,
  parameter int                  ADDR_W       = 3,
  parameter int                  LUT_BITS     = 32,
  parameter int                  HEADER_WORDS = 3,
  parameter logic [LUT_BITS-1:0] SYNC_WORD    = 32'hA5A55A5A
) (
  input  logic                clock,
  input  logic                reset,
  lut_config_loader_if.slave  bus
);
  localparam int CNT_W  = $clog2(LUT_BITS + 1);
  localparam int WORD_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HUNT   = 3'd1,
    HEADER = 3'd2,
    LOAD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LUT_BITS-1:0] sr_q, sr_d;
  logic [LUT_BITS-1:0] sr_next;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LUT_BITS-1:0] data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                word_full;

  assign sr_next   = {sr_q[LUT_BITS-2:0], bus.serial_in};
  assign word_full = (bit_cnt_q == CNT_W'(LUT_BITS - 1));

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = HUNT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
        end
      end
      HUNT: begin
        if (bus.serial_valid) begin
          sr_d = sr_next;
          // bit_cnt saturates at LUT_BITS so a stale window never fakes a sync
          if ((bit_cnt_q >= CNT_W'(LUT_BITS - 1)) && (sr_next == SYNC_WORD)) begin
            state_d    = (HEADER_WORDS > 1) ? HEADER : LOAD;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end else if (bit_cnt_q != CNT_W'(LUT_BITS)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      HEADER: begin
        if (bus.serial_valid) begin
          sr_d = sr_next;
          if (word_full) begin
            bit_cnt_d = '0;
            if (word_cnt_q == WORD_W'(HEADER_WORDS - 2)) begin
              state_d    = LOAD;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WORD_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (bus.serial_valid) begin
          sr_d = sr_next;
          if (word_full) begin
            bit_cnt_d = '0;
            wr_en_d   = 1'b1;
            addr_d    = word_cnt_q[ADDR_W-1:0];
            data_d    = sr_next;
            if (word_cnt_q == WORD_W'(NUM_LUTS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + WORD_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HUNT) || (state_d == HEADER) || (state_d == LOAD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.lut_wr_en   = wr_en_q;
  assign bus.lut_wr_addr = addr_q;
  assign bus.lut_wr_data = data_q;
  assign bus.busy        = busy_q;
  assign bus.config_done = done_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: random bitstreams against a stream-level model
// that locates the sync word and slices out the LUT words.
module tb_lut_config_loader;
  localparam int NUM_LUTS     = 8;
  localparam int ADDR_W       = 3;
  localparam int LUT_BITS     = 32;
  localparam int HEADER_WORDS = 3;
  localparam logic [31:0] SYNC_WORD = 32'hA5A55A5A;
  localparam int W = ADDR_W + LUT_BITS;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic clock;
  logic reset;
  logic [W-1:0] exp_q[$];
  bit stream_q[$];
  logic [W-1:0] mon_e;
  int n_assert;
  int n_fail;

  lut_config_loader_if #(.ADDR_W(ADDR_W), .LUT_BITS(LUT_BITS)) bus();

  lut_config_loader #(
    .NUM_LUTS(NUM_LUTS), .ADDR_W(ADDR_W), .LUT_BITS(LUT_BITS),
    .HEADER_WORDS(HEADER_WORDS), .SYNC_WORD(SYNC_WORD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of exp_q
  always @(negedge clock) begin
    if (bus.lut_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.lut_wr_addr), 64'(mon_e[W-1:LUT_BITS]));
        check("wr_data", 64'(bus.lut_wr_data), 64'(mon_e[LUT_BITS-1:0]));
        if (mon_e[W-1:LUT_BITS] == ADDR_W'(NUM_LUTS - 1)) begin
          check("done_with_last_strobe", 64'(bus.config_done), 64'd1);
          check("busy_low_last_strobe", 64'(bus.busy), 64'd0);
        end else begin
          check("done_low_mid_load", 64'(bus.config_done), 64'd0);
          check("busy_high_mid_load", 64'(bus.busy), 64'd1);
        end
      end
    end
  end

  // stream construction and reference model
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 31; i > 31 - n; i--) stream_q.push_back(v[i]);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) stream_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic push_config(input logic [31:0] first_word, input bit random_words);
    push_bits(SYNC_WORD, 32);
    for (int h = 0; h < HEADER_WORDS - 1; h++) push_bits($urandom, 32);
    for (int k = 0; k < NUM_LUTS; k++)
      push_bits(random_words ? 32'($urandom) : (first_word << (2 * k)), 32);
  endtask

  // Writes are the first NUM_LUTS whole words after the header that follows
  // the first sync window ending at or after the 32nd accepted bit.
  task automatic build_expected();
    logic [31:0] win;
    logic [31:0] w;
    int sync_end;
    int base;
    win = '0;
    sync_end = -1;
    for (int i = 0; i < stream_q.size(); i++) begin
      win = {win[30:0], stream_q[i]};
      if (i >= 31 && win == SYNC_WORD) begin
        sync_end = i;
        break;
      end
    end
    if (sync_end < 0) return;
    base = sync_end + 1 + 32 * (HEADER_WORDS - 1);
    for (int k = 0; k < NUM_LUTS; k++) begin
      if (base + 32 * (k + 1) > stream_q.size()) break;
      w = '0;
      for (int j = 0; j < 32; j++) w = {w[30:0], stream_q[base + 32 * k + j]};
      exp_q.push_back({ADDR_W'(k), w});
    end
  endtask

  // driver tasks; mode 0 continuous, 1 one valid in three, 2 random gaps
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.serial_valid = 1'b0;
      bus.serial_in    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
  endtask

  task automatic send_stream(input int mode, input int start_at);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (mode == 2) idle_cycles($urandom_range(0, 2));
      bus.serial_in    = stream_q[i];
      bus.serial_valid = 1'b1;
      bus.start        = (i == start_at);
      @(posedge clock); #1;
      bus.serial_valid = 1'b0;
      bus.start        = 1'b0;
      if (mode == 1) idle_cycles(2);
    end
    idle_cycles(1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("done_cleared_by_start", 64'(bus.config_done), 64'd0);
  endtask

  task automatic check_finished(input string tag);
    idle_cycles(3);
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_config_done"}, 64'(bus.config_done), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(bus.lut_wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(bus.lut_wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.lut_wr_data), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_config_done"}, 64'(bus.config_done), 64'd0);
    check({tag, "_state"}, 64'(bus.state_dbg), 64'(ST_IDLE));
  endtask

  task automatic run_config(input string tag, input int mode, input bit random_words,
                            input int prefix_garbage, input int sync_prefix, input int start_at);
    stream_q.delete();
    push_rand(prefix_garbage);
    push_bits(SYNC_WORD, sync_prefix);
    push_config(32'h1, random_words);
    push_rand(40);
    build_expected();
    do_start();
    send_stream(mode, start_at);
    check_finished(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.serial_in = 1'b0;
    bus.serial_valid = 1'b0;

    // async reset mid-cycle, no clock edge in between
    #23;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cycles(2);
    check_reset_outputs("idle_after_reset");

    // basic load: shifted single-bit words, continuous valid
    run_config("basic", 0, 1'b0, 0, 0, -1);

    // garbage plus a partial sync ahead of the real sync
    run_config("false_sync", 0, 1'b0, 7, 20, -1);

    // valid high one cycle in three
    run_config("sparse_valid", 1, 1'b0, 0, 0, -1);

    // reset in the middle of the fourth word
    stream_q.delete();
    push_bits(SYNC_WORD, 32);
    for (int h = 0; h < HEADER_WORDS - 1; h++) push_bits($urandom, 32);
    for (int k = 0; k < 3; k++) push_bits($urandom, 32);
    push_rand(16);
    build_expected();
    do_start();
    send_stream(0, -1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_load_reset");
    check("mid_load_pending_writes", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    stream_q.delete();
    push_bits(SYNC_WORD, 32);
    push_rand(200);
    send_stream(0, -1);
    check_reset_outputs("no_writes_without_start");

    // full reload after the reset, random words and random gaps
    run_config("reload_after_reset", 2, 1'b1, 0, 0, -1);

    // start pulsed during LOAD is ignored
    run_config("start_in_load", 0, 1'b1, 5, 0, 5 + 32 * HEADER_WORDS + 70);

    // start from DONE clears config_done and a reload works
    run_config("restart_from_done", 2, 1'b1, $urandom_range(0, 40), 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
